// File: rtl/astar_resp_splitter_pkg.sv
// Shared types for the A* response splitter: task context carried per request
// and the tracking entry held in the in-order FIFO.
package swarm;

    typedef logic [63:0] data_t;
    typedef logic [7:0]  byte_t;
    typedef logic [2:0]  subtype_t;
    typedef logic [3:0]  cq_slice_slot_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] locale;
        logic [3:0]  ttype;
    } task_t;

    typedef struct packed {
        task_t          task_ctx;
        subtype_t       subtype;
        logic           mark_last;
        cq_slice_slot_t cq_slot;
        logic [7:0]     arlen;
    } astar_resp_trk_t;

endpackage

// File: rtl/astar_resp_splitter_if.sv
// Request, memory read-address/read-data and output-task channels of the splitter.
interface astar_resp_splitter_if;
  import swarm::*;

  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_araddr;
  logic [7:0]     req_arlen;
  logic [2:0]     req_arsize;
  task_t          req_task;
  subtype_t       req_subtype;
  logic           req_mark_last;
  cq_slice_slot_t req_cq_slot;

  logic           mem_arvalid;
  logic           mem_arready;
  logic [31:0]    mem_araddr;
  logic [7:0]     mem_arlen;
  logic [2:0]     mem_arsize;
  logic           mem_rvalid;
  logic           mem_rready;
  logic [63:0]    mem_rdata;
  logic           mem_rlast;

  logic           out_valid;
  logic           out_ready;
  task_t          out_task;
  data_t          out_data;
  byte_t          out_word_id;
  subtype_t       out_subtype;
  cq_slice_slot_t out_cq_slot;
  logic           out_last;

  modport slave (
    input  req_valid, req_araddr, req_arlen, req_arsize, req_task, req_subtype,
           req_mark_last, req_cq_slot, mem_arready, mem_rvalid, mem_rdata, mem_rlast,
           out_ready,
    output req_ready, mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_rready,
           out_valid, out_task, out_data, out_word_id, out_subtype, out_cq_slot, out_last
  );

  modport master (
    output req_valid, req_araddr, req_arlen, req_arsize, req_task, req_subtype,
           req_mark_last, req_cq_slot, mem_arready, mem_rvalid, mem_rdata, mem_rlast,
           out_ready,
    input  req_ready, mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_rready,
           out_valid, out_task, out_data, out_word_id, out_subtype, out_cq_slot, out_last
  );

endinterface

// File: rtl/astar_resp_splitter_fifo.sv
// Show-ahead synchronous FIFO; push is ignored when full, pop when empty.
module fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]   mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_r;
  logic [LOG_DEPTH:0] rd_ptr_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[LOG_DEPTH] != rd_ptr_r[LOG_DEPTH]) &&
                     (wr_ptr_r[LOG_DEPTH-1:0] == rd_ptr_r[LOG_DEPTH-1:0]);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem[rd_ptr_r[LOG_DEPTH-1:0]];

  // Read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{LOG_DEPTH{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{LOG_DEPTH{1'b0}}, 1'b1};
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wr_ptr_r[LOG_DEPTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/astar_resp_splitter.sv
// Forwards worker reads to memory and unrolls in-order response beats into child tasks.
// Optional statistics counters on log_output when ASTAR_RESP_STATS_EN is defined.
module astar_resp_splitter
  import swarm::*;
#(
  parameter int TILE_ID   = 0,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  astar_resp_splitter_if.slave bus,
  output logic                 err_orphan,
  output logic                 err_len,
  output logic [31:0]          log_output
);

  astar_resp_trk_t push_entry_s;
  astar_resp_trk_t head_s;
  logic            trk_full_s;
  logic            trk_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            beat_acc_s;
  logic            beat_ok_s;
  logic [7:0]      beat_cnt_r;
  logic            out_valid_r;
  task_t           out_task_r;
  data_t           out_data_r;
  byte_t           out_word_id_r;
  subtype_t        out_subtype_r;
  cq_slice_slot_t  out_cq_slot_r;
  logic            out_last_r;
  logic            err_orphan_r;
  logic            err_len_r;

  assign bus.mem_arvalid = bus.req_valid & ~trk_full_s;
  assign bus.req_ready   = bus.mem_arready & ~trk_full_s;
  assign bus.mem_araddr  = bus.req_araddr;
  assign bus.mem_arlen   = bus.req_arlen;
  assign bus.mem_arsize  = bus.req_arsize;
  assign push_s          = bus.req_valid & bus.req_ready;

  assign push_entry_s = '{task_ctx:  bus.req_task,   subtype: bus.req_subtype,
                          mark_last: bus.req_mark_last, cq_slot: bus.req_cq_slot,
                          arlen:     bus.req_arlen};

  assign bus.mem_rready = ~out_valid_r | bus.out_ready;
  assign beat_acc_s     = bus.mem_rvalid & bus.mem_rready;
  assign beat_ok_s      = beat_acc_s & ~trk_empty_s;
  assign pop_s          = beat_ok_s & bus.mem_rlast;

  fifo #(
    .WIDTH     ($bits(astar_resp_trk_t)),
    .LOG_DEPTH (LOG_DEPTH)
  ) TRK_FIFO (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (trk_full_s),
    .empty (trk_empty_s)
  );

  // Output register, beat counter and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_task_r    <= '0;
      out_data_r    <= '0;
      out_word_id_r <= 8'd0;
      out_subtype_r <= '0;
      out_cq_slot_r <= '0;
      out_last_r    <= 1'b0;
      beat_cnt_r    <= 8'd0;
      err_orphan_r  <= 1'b0;
      err_len_r     <= 1'b0;
    end else begin
      if (beat_acc_s && trk_empty_s) err_orphan_r <= 1'b1;
      if (beat_ok_s) begin
        out_valid_r   <= 1'b1;
        out_task_r    <= head_s.task_ctx;
        out_data_r    <= bus.mem_rdata;
        out_word_id_r <= beat_cnt_r;
        out_subtype_r <= head_s.subtype;
        out_cq_slot_r <= head_s.cq_slot;
        out_last_r    <= head_s.mark_last & bus.mem_rlast;
        // Length mismatch either way: early rlast, or arlen reached without rlast.
        if (bus.mem_rlast != (beat_cnt_r == head_s.arlen)) err_len_r <= 1'b1;
        beat_cnt_r    <= bus.mem_rlast ? 8'd0 : beat_cnt_r + 8'd1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.out_task    = out_task_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_word_id = out_word_id_r;
  assign bus.out_subtype = out_subtype_r;
  assign bus.out_cq_slot = out_cq_slot_r;
  assign bus.out_last    = out_last_r;
  assign err_orphan      = err_orphan_r;
  assign err_len         = err_len_r;

`ifdef ASTAR_RESP_STATS_EN
  logic [11:0] st_req_r;
  logic [11:0] st_beat_r;
  logic [7:0]  st_stall_r;

  // Saturating request / emitted-beat / stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_req_r   <= 12'd0;
      st_beat_r  <= 12'd0;
      st_stall_r <= 8'd0;
    end else begin
      if (push_s && st_req_r != 12'hFFF)     st_req_r   <= st_req_r + 12'd1;
      if (beat_ok_s && st_beat_r != 12'hFFF) st_beat_r  <= st_beat_r + 12'd1;
      if (out_valid_r && !bus.out_ready && st_stall_r != 8'hFF)
        st_stall_r <= st_stall_r + 8'd1;
    end
  end

  assign log_output = {st_req_r, st_beat_r, st_stall_r};
`else
  assign log_output = 32'd0;
`endif

endmodule

// File: tb/tb_astar_resp_splitter.sv
// Directed self-checking bench for astar_resp_splitter.
module tb_astar_resp_splitter;
  import swarm::*;

  logic        clk;
  logic        rst;
  logic        err_orphan;
  logic        err_len;
  logic [31:0] log_output;
  int          checks;
  int          errors;

  astar_resp_splitter_if bus ();

  astar_resp_splitter #(.TILE_ID(0), .LOG_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_orphan (err_orphan),
    .err_len    (err_len),
    .log_output (log_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] len, input logic [31:0] ts, input logic [15:0] loc,
                         input logic ml, input logic [3:0] slot);
    bus.req_valid     = 1'b1;
    bus.req_araddr    = ts * 32'd8;
    bus.req_arlen     = len;
    bus.req_arsize    = 3'd3;
    bus.req_task      = '{ts: ts, locale: loc, ttype: 4'd1};
    bus.req_subtype   = 3'd2;
    bus.req_mark_last = ml;
    bus.req_cq_slot   = slot;
  endtask

  task automatic issue(input logic [7:0] len, input logic [31:0] ts, input logic [15:0] loc,
                       input logic ml, input logic [3:0] slot);
    set_req(len, ts, loc, ml, slot);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic beat(input logic [63:0] data, input logic last);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    bus.mem_rlast  = last;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_word_id !== 8'd0) begin errors++; $display("FAIL reset_word_id got %0d exp 0", bus.out_word_id); end
    checks++; if ({err_orphan, err_len} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_orphan, err_len}); end
    checks++; if (log_output !== 32'd0) begin errors++; $display("FAIL reset_log got %h exp 0", log_output); end
    rst = 1'b0;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", bus.req_ready); end
    checks++; if (bus.mem_rready !== 1'b1) begin errors++; $display("FAIL reset_rready got %0b exp 1", bus.mem_rready); end
  endtask

  task automatic test_single();
    set_req(8'd0, 32'd100, 16'd7, 1'b1, 4'd3);
    #1;
    checks++; if (bus.mem_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got %0b exp 1", bus.mem_arvalid); end
    checks++; if (bus.mem_araddr !== 32'd800) begin errors++; $display("FAIL single_araddr got %0d exp 800", bus.mem_araddr); end
    step();
    bus.req_valid = 1'b0;
    beat(64'h0000_0005_0000_0003, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 64'h0000_0005_0000_0003) begin errors++; $display("FAIL single_data got %h exp 0000000500000003", bus.out_data); end
    checks++; if (bus.out_word_id !== 8'd0) begin errors++; $display("FAIL single_word got %0d exp 0", bus.out_word_id); end
    checks++; if (bus.out_task.ts !== 32'd100) begin errors++; $display("FAIL single_ts got %0d exp 100", bus.out_task.ts); end
    checks++; if (bus.out_task.locale !== 16'd7) begin errors++; $display("FAIL single_locale got %0d exp 7", bus.out_task.locale); end
    checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL single_last got %0b exp 1", bus.out_last); end
    checks++; if (bus.out_cq_slot !== 4'd3) begin errors++; $display("FAIL single_slot got %0d exp 3", bus.out_cq_slot); end
    checks++; if (bus.out_subtype !== 3'd2) begin errors++; $display("FAIL single_subtype got %0d exp 2", bus.out_subtype); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_burst();
    issue(8'd3, 32'd150, 16'd9, 1'b1, 4'd5);
    for (int i = 0; i < 4; i++) begin
      beat(64'h1000 + 64'(i), (i == 3));
      checks++; if (bus.out_word_id !== 8'(i)) begin errors++; $display("FAIL burst_word%0d got %0d exp %0d", i, bus.out_word_id, i); end
      checks++; if (bus.out_last !== (i == 3)) begin errors++; $display("FAIL burst_last%0d got %0b exp %0b", i, bus.out_last, (i == 3)); end
      checks++; if (bus.out_data !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL burst_data%0d got %h exp %h", i, bus.out_data, 64'h1000 + 64'(i)); end
    end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL burst_err_len got %0b exp 0", err_len); end
  endtask

  task automatic test_backpressure();
    issue(8'd3, 32'd200, 16'd2, 1'b0, 4'd1);
    beat(64'hA0, 1'b0);
    bus.out_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hA1;
    #1;
    checks++; if (bus.mem_rready !== 1'b0) begin errors++; $display("FAIL bp_rready got %0b exp 0", bus.mem_rready); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_word_id !== 8'd0 || bus.out_data !== 64'hA0) begin
        errors++; $display("FAIL bp_hold%0d got v=%0b w=%0d d=%h exp v=1 w=0 d=a0", k, bus.out_valid, bus.out_word_id, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.mem_rdata = 64'hA0 + 64'(i);
      bus.mem_rlast = (i == 3);
      step();
      checks++; if (bus.out_word_id !== 8'(i) || bus.out_data !== 64'hA0 + 64'(i)) begin
        errors++; $display("FAIL bp_resume%0d got w=%0d d=%h exp w=%0d d=%h", i, bus.out_word_id, bus.out_data, i, 64'hA0 + 64'(i));
      end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL bp_last%0d got %0b exp 0", i, bus.out_last); end
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_req(8'd0, 32'(i), 16'd4, 1'b0, 4'd0);
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d got %0b exp 1", i, bus.req_ready); end
      step();
    end
    set_req(8'd0, 32'd16, 16'd4, 1'b0, 4'd0);
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready16 got %0b exp 0", bus.req_ready); end
    checks++; if (bus.mem_arvalid !== 1'b0) begin errors++; $display("FAIL full_arvalid got %0b exp 0", bus.mem_arvalid); end
    beat(64'h0, 1'b1);
    checks++; if (bus.out_task.ts !== 32'd0) begin errors++; $display("FAIL full_first_ts got %0d exp 0", bus.out_task.ts); end
    checks++; if (bus.req_ready !== 1'b1 || bus.mem_arvalid !== 1'b1) begin
      errors++; $display("FAIL full_reenable got ready=%0b arvalid=%0b exp 1 1", bus.req_ready, bus.mem_arvalid);
    end
    step();
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      beat(64'(i), 1'b1);
      checks++; if (bus.out_task.ts !== 32'(i) || bus.out_word_id !== 8'd0) begin
        errors++; $display("FAIL full_drain%0d got ts=%0d w=%0d exp ts=%0d w=0", i, bus.out_task.ts, bus.out_word_id, i);
      end
    end
  endtask

  task automatic test_errors();
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL err_orphan_pre got %0b exp 0", err_orphan); end
    beat(64'hDEAD, 1'b1);
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL err_orphan got %0b exp 1", err_orphan); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL err_orphan_valid got %0b exp 0", bus.out_valid); end
    issue(8'd2, 32'd300, 16'd1, 1'b1, 4'd2);
    beat(64'hB0, 1'b0);
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_len_pre got %0b exp 0", err_len); end
    beat(64'hB1, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_word_id !== 8'd1 || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL err_len_beat got v=%0b w=%0d l=%0b exp 1 1 1", bus.out_valid, bus.out_word_id, bus.out_last);
    end
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL err_len got %0b exp 1", err_len); end
    issue(8'd0, 32'd400, 16'd1, 1'b0, 4'd2);
    beat(64'hC0, 1'b1);
    checks++; if (bus.out_task.ts !== 32'd400 || bus.out_word_id !== 8'd0) begin
      errors++; $display("FAIL err_len_popped got ts=%0d w=%0d exp ts=400 w=0", bus.out_task.ts, bus.out_word_id);
    end
  endtask

  task automatic test_reset_mid_burst();
    issue(8'd3, 32'd500, 16'd3, 1'b1, 4'd6);
    beat(64'hE0, 1'b0);
    beat(64'hE1, 1'b0);
    checks++; if (bus.out_word_id !== 8'd1) begin errors++; $display("FAIL rmb_pre got %0d exp 1", bus.out_word_id); end
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_task !== '0) begin
      errors++; $display("FAIL rmb_clear got v=%0b d=%h exp v=0 d=0", bus.out_valid, bus.out_data);
    end
    checks++; if ({err_orphan, err_len} !== 2'b00) begin errors++; $display("FAIL rmb_err got %b exp 00", {err_orphan, err_len}); end
    step();
    rst = 1'b0;
    beat(64'hE2, 1'b0);
    checks++; if (err_orphan !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rmb_orphan got orphan=%0b v=%0b exp 1 0", err_orphan, bus.out_valid);
    end
    issue(8'd1, 32'd600, 16'd3, 1'b1, 4'd6);
    beat(64'hF0, 1'b0);
    checks++; if (bus.out_word_id !== 8'd0 || bus.out_task.ts !== 32'd600) begin
      errors++; $display("FAIL rmb_restart got w=%0d ts=%0d exp w=0 ts=600", bus.out_word_id, bus.out_task.ts);
    end
    beat(64'hF1, 1'b1);
    checks++; if (bus.out_word_id !== 8'd1 || bus.out_last !== 1'b1) begin
      errors++; $display("FAIL rmb_second got w=%0d l=%0b exp w=1 l=1", bus.out_word_id, bus.out_last);
    end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL rmb_err_len got %0b exp 0", err_len); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_araddr = 32'd0;
    bus.req_arlen = 8'd0;
    bus.req_arsize = 3'd0;
    bus.req_task = '0;
    bus.req_subtype = '0;
    bus.req_mark_last = 1'b0;
    bus.req_cq_slot = '0;
    bus.mem_arready = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 64'd0;
    bus.mem_rlast = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full();
    test_errors();
    test_reset_mid_burst();
`ifndef ASTAR_RESP_STATS_EN
    checks++; if (log_output !== 32'd0) begin errors++; $display("FAIL log_tied got %h exp 0", log_output); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
